// File: rtl/dm_mem_ctrl.sv
// Data-memory controller: word-addressed SRAM behind a request/ready handshake with
// WAIT_CYCLES wait states. Optional macro DM_POSTED_WRITE_EN makes writes complete on accept.
module dm_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DM_enable,
  input  logic                  DM_read,
  input  logic                  DM_write,
  input  logic [ADDR_WIDTH-1:0] DM_address,
  input  logic [DATA_WIDTH-1:0] DM_in,
  output logic [DATA_WIDTH-1:0] DM_out,
  output logic                  DM_ready,
  output logic                  busy
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WAIT_CYCLES);

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  logic                  state_q, state_d;
  logic                  op_q, op_d;  // 1 = read
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  // Storage is deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [Depth];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    busy_d    = busy_q;
    ready_d   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
    case (state_q)
      StIdle: begin
        if (DM_enable && (DM_read || DM_write)) begin
          op_d    = DM_read;
          addr_d  = DM_address;
          wdata_d = DM_in;
`ifdef DM_POSTED_WRITE_EN
          if (!DM_read) begin
            mem_we    = 1'b1;
            mem_waddr = DM_address;
            mem_wdata = DM_in;
            ready_d   = 1'b1;
          end else begin
            cnt_d   = CntInit;
            state_d = StBusy;
            busy_d  = 1'b1;
          end
`else
          cnt_d   = CntInit;
          state_d = StBusy;
          busy_d  = 1'b1;
`endif
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          if (op_q) out_d = mem[addr_q];
          else mem_we = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Gated by rst so an edge seen while reset is held can never commit a write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  assign DM_out   = out_q;
  assign DM_ready = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dm_mem_ctrl.sv
// Directed bench for dm_mem_ctrl: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance
// share data inputs but have separate request strobes.
module tb_dm_mem_ctrl;

`ifdef DM_POSTED_WRITE_EN
  localparam bit Posted = 1'b1;
`else
  localparam bit Posted = 1'b0;
`endif

  typedef struct {
    bit          sel;       // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0 instance
    logic [1:0]  op;        // {write, read}
    logic [11:0] addr;
    logic [31:0] data;
    int          exp_lat;   // edges after accept until ready; -1 = never
    logic        exp_busy;
    logic [31:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en2 = 1'b0, en0 = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] out2, out0;
  logic        ready2, ready0, busy2, busy0;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] model_out [2];

  always #5 clk = ~clk;

  dm_mem_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .DM_enable(en2), .DM_read(rd), .DM_write(wr),
    .DM_address(addr), .DM_in(din), .DM_out(out2), .DM_ready(ready2), .busy(busy2)
  );

  dm_mem_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .DM_enable(en0), .DM_read(rd), .DM_write(wr),
    .DM_address(addr), .DM_in(din), .DM_out(out0), .DM_ready(ready0), .busy(busy0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic ready_of(input bit sel);
    return sel ? ready0 : ready2;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy0 : busy2;
  endfunction

  function automatic logic [31:0] out_of(input bit sel);
    return sel ? out0 : out2;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    rd   = v.op[0];
    wr   = v.op[1];
    addr = v.addr;
    din  = v.data;
    if (v.sel) en0 = 1'b1;
    else en2 = 1'b1;
    @(posedge clk); #1;
    check($sformatf("v%0d_busy", idx), 32'(busy_of(v.sel)), 32'(v.exp_busy));
    lat = ready_of(v.sel) ? 0 : -1;
    // Scramble inputs while the request is in flight.
    @(negedge clk);
    en2 = 1'b0; en0 = 1'b0; rd = 1'b0; wr = 1'b1; addr = 12'h3ff; din = 32'hffff_ffff;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (ready_of(v.sel)) lat = c;
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    if (v.op[0] && lat >= 0) begin
      check($sformatf("v%0d_rdata", idx), out_of(v.sel), v.exp_data);
      model_out[v.sel] = v.exp_data;
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
      check($sformatf("v%0d_ready_width", idx), 32'(ready_of(v.sel)), 32'd0);
    end
    check($sformatf("v%0d_out_hold", idx), out_of(v.sel), model_out[v.sel]);
    wr = 1'b0;
  endtask

  vec_t vecs [13];

  initial begin
    int lw2, lw0, p, hits;
    logic bw;
    lw2 = Posted ? 0 : 3;
    lw0 = Posted ? 0 : 1;
    bw  = Posted ? 1'b0 : 1'b1;
    vecs[0]  = '{1'b0, 2'b10, 12'h010, 32'hdead_beef, lw2, bw,   32'h0};
    vecs[1]  = '{1'b0, 2'b01, 12'h010, 32'h0,         3,   1'b1, 32'hdead_beef};
    vecs[2]  = '{1'b0, 2'b10, 12'h001, 32'h1111_1111, lw2, bw,   32'h0};
    vecs[3]  = '{1'b0, 2'b10, 12'h002, 32'h2222_2222, lw2, bw,   32'h0};
    vecs[4]  = '{1'b1, 2'b10, 12'hfff, 32'h1234_5678, lw0, bw,   32'h0};
    vecs[5]  = '{1'b1, 2'b01, 12'hfff, 32'h0,         1,   1'b1, 32'h1234_5678};
    vecs[6]  = '{1'b0, 2'b00, 12'h010, 32'h5555_5555, -1,  1'b0, 32'h0};
    vecs[7]  = '{1'b0, 2'b11, 12'h010, 32'h0bad_f00d, 3,   1'b1, 32'hdead_beef};
    vecs[8]  = '{1'b0, 2'b01, 12'h010, 32'h0,         3,   1'b1, 32'hdead_beef};
    vecs[9]  = '{1'b0, 2'b10, 12'h020, 32'ha5a5_a5a5, lw2, bw,   32'h0};
    vecs[10] = '{1'b0, 2'b01, 12'h020, 32'h0,         3,   1'b1, 32'ha5a5_a5a5};
    vecs[11] = '{1'b0, 2'b10, 12'h010, 32'hcafe_f00d, lw2, bw,   32'h0};
    vecs[12] = '{1'b0, 2'b01, 12'h010, 32'h0,         3,   1'b1, 32'hcafe_f00d};
    model_out[0] = '0;
    model_out[1] = '0;

    #12;
    check("rst_ready", 32'(ready2), 32'd0);
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_out", out2, 32'd0);
    check("rst_out_w0", out0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Held strobe: reads alternate 0x001/0x002, next address driven while busy.
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; addr = 12'h001; en2 = 1'b1;
    p = 0;
    for (int e = 0; e < 24 && p < 4; e++) begin
      @(posedge clk); #1;
      if (e % 4 == 0) addr = ((e / 4 + 1) % 2 == 0) ? 12'h001 : 12'h002;
      if (ready2) begin
        check($sformatf("hs%0d_edge", p), 32'(e), 32'(4 * p + 3));
        check($sformatf("hs%0d_data", p), out2, (p % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
        p++;
        if (p == 4) begin
          en2 = 1'b0;
          rd  = 1'b0;
        end
      end
    end
    check("hs_pulses", 32'(p), 32'd4);
    en2 = 1'b0;
    rd  = 1'b0;
    model_out[0] = 32'h2222_2222;
    @(posedge clk); #1;
    check("hs_idle", 32'(busy2), 32'd0);

    // Reset in the middle of a pending read.
    @(negedge clk);
    rd = 1'b1; addr = 12'h010; en2 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    en2 = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready2), 32'd0);
    check("mid_rst_busy", 32'(busy2), 32'd0);
    check("mid_rst_out", out2, 32'd0);
    check("mid_rst_out_w0", out0, 32'd0);
    model_out[0] = '0;
    model_out[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    rd  = 1'b0;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ready2) hits++;
    end
    check("aborted_no_ready", 32'(hits), 32'd0);
    run_vec('{1'b0, 2'b01, 12'h010, 32'h0, 3, 1'b1, 32'hcafe_f00d}, 13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
